dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Sits between the processor core's data-memory access signals (address, write data, write enable, load/store request) and the single-port data memory. Shares that memory with an external host port used for loading and unloading data and for debug. The core has default priority. A bounded-wait counter guarantees host progress, and a lock mode gives the host back-to-back bursts. Whenever the core loses the port it receives a stall that freezes the PC and register-file write.

Parameters:
AW, 8, memory address width
DW, 8, memory data width
MAXWAIT, 4, consecutive contended cycles the host may be refused before a forced host grant (1..15)
SCW, 16, width of saturating stall statistics counter

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
core_req  input  1  core performs a load or store this cycle
core_we  input  1  core access is a store
core_addr  input  AW  core address
core_wdata  input  DW  core store data
core_rdata  output  DW  load data to core, combinational from mem_dat_out
core_stall  output  1  core must hold PC and suppress register write this cycle
host_req  input  1  host access request, held until granted
host_we  input  1  host access is a write
host_lock  input  1  host requests burst ownership
host_addr  input  AW  host address
host_wdata  input  DW  host write data
host_gnt  output  1  host access performed this cycle
host_rdata  output  DW  registered host read data
host_rvalid  output  1  host_rdata valid, one cycle after a granted read
mem_wr_en  output  1  to data memory write enable
mem_addr  output  AW  to data memory address
mem_dat_in  output  DW  to data memory write data
mem_dat_out  input  DW  from data memory, asynchronous read
stall_count  output  SCW  saturating count of cycles with core_stall=1

Behaviour:
- Reset (reset=0, async): state=S_CORE, wait_cnt=0, host_rdata=0, host_rvalid=0, stall_count=0. While reset is low: host_gnt=0, core_stall=0, mem_wr_en=0.
- Ownership is decided combinationally each cycle. The memory mux follows the owner: mem_addr, mem_dat_in, and mem_wr_en=(owner's we AND owner's req). With no request, mem_addr=core_addr and mem_wr_en=0.
- FSM states: S_CORE (normal arbitration) and S_LOCK (host burst).
- S_CORE rules:
  - host_req=0: core owns; host_gnt=0; core_stall=0; wait_cnt<=0.
  - host_req=1, core_req=0: host owns, host_gnt=1, wait_cnt<=0.
  - host_req=1, core_req=1, wait_cnt<MAXWAIT: core owns, host_gnt=0, wait_cnt<=wait_cnt+1.
  - host_req=1, core_req=1, wait_cnt==MAXWAIT: host owns, host_gnt=1, core_stall=1, wait_cnt<=0.
  - Whenever the host is granted in S_CORE and host_lock=1: next state is S_LOCK.
- S_LOCK rules:
  - The host owns every cycle. host_gnt=host_req. core_stall=core_req.
  - host_lock=0 sampled: next state is S_CORE.
  - host_req is not required every cycle. Idle lock cycles still stall a requesting core.
- A stalled core's store does not write memory; the core repeats it next cycle because the PC is held.
- A granted host read sets host_rdata<=mem_dat_out and host_rvalid<=1 on the next edge; otherwise host_rvalid<=0. host_rdata holds its value until the next granted read.
- core_rdata=mem_dat_out always. It is meaningful only when core_req=1 and core_stall=0.
- Simultaneous store collisions are impossible by construction: exactly one writer per cycle.
- stall_count increments on every edge where core_stall=1 and saturates at all-ones.
- wait_cnt is held in S_LOCK and cleared on exit.
- Reset asserted mid-burst returns to S_CORE immediately; outputs take reset values asynchronously.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - typedef enum owner_t {OWN_CORE, OWN_HOST}
  - typedef enum arb_state_t {S_CORE, S_LOCK}
  - default MAXWAIT constant
- One natural sub-module, arb_wait_ctr: the bounded wait counter with inc/clr inputs and an at_max output.
- FSM, mux and read-data register stay in dmem_arbiter.

Test Plan:
- Release reset, host idle, core stores 0x5A to addr 0x10 → mem_wr_en=1, mem_addr=0x10, core_stall=0, stall_count=0.
- Core idle, host reads addr 0x10 → host_gnt=1 same cycle; next cycle host_rvalid=1 and host_rdata=0x5A; the following cycle host_rvalid=0.
- MAXWAIT=4, core_req=1 every cycle, host write 0x33 to 0x20 held → host_gnt=0 for 4 cycles; 5th cycle host_gnt=1, core_stall=1, mem[0x20]=0x33, core store suppressed; stall_count=1.
- Host granted with host_lock=1, holds lock 3 more cycles writing 0x01..0x03 to 0x30..0x32 with core_req=1 → core_stall=1 for 4 cycles, stall_count+=4; lock drop → S_CORE, core regains port next cycle.
- Assert reset=0 during S_LOCK with core_req=1 → core_stall=0, host_gnt=0, mem_wr_en=0 immediately; after release, state is S_CORE and stall_count=0.
- Force stall_count to near all-ones (SCW=4, 17 stall cycles) → count saturates at 0xF.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   owner_t      : which requester drives the memory port in a cycle
//   arb_state_t  : arbitration FSM states (normal / host burst lock)
//   MAXWAIT_DEFAULT : default number of refused contended host cycles
//   WAIT_CW      : width of the bounded-wait counter (MAXWAIT <= 15)
package dmem_arb_pkg;

   typedef enum logic {
      OWN_CORE = 1'b0,
      OWN_HOST = 1'b1
   } owner_t;

   typedef enum logic {
      S_CORE = 1'b0,
      S_LOCK = 1'b1
   } arb_state_t;

   localparam int unsigned MAXWAIT_DEFAULT = 4;
   localparam int unsigned WAIT_CW         = 4;

endpackage

// File: rtl/arb_wait_ctr.sv
// Bounded-wait counter: counts consecutive contended cycles in which the host
// was refused the memory port.
//   clk, reset : clock, asynchronous active-low reset
//   inc        : host refused this cycle, count up
//   clr        : clear the count (takes priority over inc)
//   at_max     : count has reached MAXWAIT, host must be granted next contention
module arb_wait_ctr
   import dmem_arb_pkg::*;
#(
   parameter int unsigned MAXWAIT = MAXWAIT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic at_max
);

   localparam logic [WAIT_CW-1:0] MaxVal = WAIT_CW'(MAXWAIT);

   logic [WAIT_CW-1:0] cnt_q;
   logic [WAIT_CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != MaxVal)) begin
         cnt_d = cnt_q + WAIT_CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_max = (cnt_q == MaxVal);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the processor core and an external host port.
// The core has default priority; a bounded-wait counter forces a host grant
// after MAXWAIT refused contended cycles, and host_lock gives the host burst
// ownership. A core that loses the port sees core_stall for that cycle.
//   clk, reset        : clock, asynchronous active-low reset
//   core_req/we/addr/wdata, core_rdata, core_stall : core data-memory side
//   host_req/we/lock/addr/wdata, host_gnt, host_rdata, host_rvalid : host side
//   mem_wr_en, mem_addr, mem_dat_in, mem_dat_out : single-port memory
//   stall_count       : saturating count of stalled core cycles
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned AW      = 8,
   parameter int unsigned DW      = 8,
   parameter int unsigned MAXWAIT = MAXWAIT_DEFAULT,
   parameter int unsigned SCW     = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic [DW-1:0] core_rdata,
   output logic          core_stall,
   input  logic          host_req,
   input  logic          host_we,
   input  logic          host_lock,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_gnt,
   output logic [DW-1:0] host_rdata,
   output logic          host_rvalid,
   output logic          mem_wr_en,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_dat_in,
   input  logic [DW-1:0] mem_dat_out,
   output logic [SCW-1:0] stall_count
);

   arb_state_t state_q, state_d;
   owner_t     owner;
   logic       gnt_c;
   logic       stall_c;
   logic       wr_c;
   logic       wait_inc;
   logic       wait_clr;
   logic       wait_at_max;

   arb_wait_ctr #(
      .MAXWAIT (MAXWAIT)
   ) u_wait_ctr (
      .clk    (clk),
      .reset  (reset),
      .inc    (wait_inc),
      .clr    (wait_clr),
      .at_max (wait_at_max)
   );

   // Ownership, grant, stall and next state are all decided in the same cycle.
   always_comb begin
      state_d  = state_q;
      owner    = OWN_CORE;
      gnt_c    = 1'b0;
      stall_c  = 1'b0;
      wait_inc = 1'b0;
      wait_clr = 1'b0;
      unique case (state_q)
         S_CORE: begin
            if (!host_req) begin
               wait_clr = 1'b1;
            end else if (!core_req) begin
               owner    = OWN_HOST;
               gnt_c    = 1'b1;
               wait_clr = 1'b1;
            end else if (!wait_at_max) begin
               wait_inc = 1'b1;
            end else begin
               // Host has waited long enough: take the port from the core.
               owner    = OWN_HOST;
               gnt_c    = 1'b1;
               stall_c  = 1'b1;
               wait_clr = 1'b1;
            end
            if (gnt_c && host_lock) begin
               state_d = S_LOCK;
            end
         end
         S_LOCK: begin
            // Host owns the port even on idle lock cycles; wait count is held.
            owner   = OWN_HOST;
            gnt_c   = host_req;
            stall_c = core_req;
            if (!host_lock) begin
               state_d  = S_CORE;
               wait_clr = 1'b1;
            end
         end
         default: begin
            state_d = S_CORE;
         end
      endcase
   end

   // Memory port mux follows the owner; only the owner can ever write.
   always_comb begin
      mem_addr   = core_addr;
      mem_dat_in = core_wdata;
      wr_c       = core_req & core_we;
      if (owner == OWN_HOST) begin
         mem_addr   = host_addr;
         mem_dat_in = host_wdata;
         wr_c       = host_req & host_we;
      end
   end

   // Combinational handshakes are forced inactive while reset is held low.
   assign host_gnt   = gnt_c & reset;
   assign core_stall = stall_c & reset;
   assign mem_wr_en  = wr_c & reset;
   assign core_rdata = mem_dat_out;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_CORE;
         host_rdata  <= '0;
         host_rvalid <= 1'b0;
         stall_count <= '0;
      end else begin
         state_q     <= state_d;
         host_rvalid <= gnt_c & ~host_we;
         if (gnt_c && !host_we) begin
            host_rdata <= mem_dat_out;
         end
         if (stall_c && (stall_count != '1)) begin
            stall_count <= stall_count + SCW'(1);
         end
      end
   end

endmodule
